// File: rtl/sift_win_pkg.sv
// Shared types and defaults for the SIFT 3x3 window scan controller.
// Provides the FSM state enum, window size and default image geometry.
package sift_win_pkg;

    localparam int WIN_SIZE  = 3;
    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;
    localparam int COL_W_DEF = 10;
    localparam int ROW_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/raster_pos_counter.sv
// Raster column/row position counter with enable, clear and line/frame wrap.
// Ports: iclk, irst_n, ien (advance), iclr (to 0,0), ocol, orow, olast (at last pixel).
module raster_pos_counter #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int COL_W = 10,
    parameter int ROW_W = 9
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             ien,
    input  logic             iclr,
    output logic [COL_W-1:0] ocol,
    output logic [ROW_W-1:0] orow,
    output logic             olast
);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (iclr) begin
            col_d = '0;
            row_d = '0;
        end else if (ien) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                // Wrap the row too so the next frame starts clean at (0,0).
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign ocol  = col_q;
    assign orow  = row_q;
    assign olast = (col_q == COL_LAST) && (row_q == ROW_LAST);

endmodule

// File: rtl/window_scan_ctrl.sv
// Sequences the 3x3 neighbourhood datapath: raster tracking, shift enable, window flags.
// Ports: iclk, irst_n, istart, ivalid -> oshift_en, owin_valid, ocx, ocy, osof, oframe_done, obusy, oerr.
module window_scan_ctrl
    import sift_win_pkg::*;
#(
    parameter int IMG_W = IMG_W_DEF,
    parameter int IMG_H = IMG_H_DEF,
    parameter int COL_W = COL_W_DEF,
    parameter int ROW_W = ROW_W_DEF
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             istart,
    input  logic             ivalid,
    output logic             oshift_en,
    output logic             owin_valid,
    output logic [COL_W-1:0] ocx,
    output logic [ROW_W-1:0] ocy,
    output logic             osof,
    output logic             oframe_done,
    output logic             obusy,
    output logic             oerr
);

    localparam logic [COL_W-1:0] COL_EDGE = COL_W'(WIN_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_EDGE = ROW_W'(WIN_SIZE - 1);

    state_e state_q, state_d;

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             last;
    logic             busy;
    logic             accept;
    logic             first_win;
    logic             interior;

    logic             win_q, win_d;
    logic [COL_W-1:0] cx_q, cx_d;
    logic [ROW_W-1:0] cy_q, cy_d;
    logic             sof_q, sof_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    assign busy      = (state_q == FILL) || (state_q == RUN);
    assign oshift_en = ivalid & busy;
    // A restart in the same cycle discards the pixel from the frame count.
    assign accept    = oshift_en & ~istart;
    assign interior  = (col >= COL_EDGE) && (row >= ROW_EDGE);
    assign first_win = (col == COL_EDGE) && (row == ROW_EDGE);

    raster_pos_counter #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_pos (
        .iclk   (iclk),
        .irst_n (irst_n),
        .ien    (accept),
        .iclr   (istart),
        .ocol   (col),
        .orow   (row),
        .olast  (last)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (istart) state_d = FILL;
            FILL: begin
                if (istart)              state_d = FILL;
                else if (accept && last) state_d = DONE;
                else if (accept && first_win) state_d = RUN;
            end
            RUN: begin
                if (istart)              state_d = FILL;
                else if (accept && last) state_d = DONE;
            end
            DONE: state_d = istart ? FILL : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        win_d  = accept & interior;
        cx_d   = cx_q;
        cy_d   = cy_q;
        if (win_d) begin
            cx_d = col - COL_W'(1);
            cy_d = row - ROW_W'(1);
        end
        sof_d  = accept & first_win;
        done_d = accept & last;
        err_d  = (ivalid & ~busy) | (istart & busy);
    end

    always_ff @(posedge iclk or negedge irst_n) begin
        if (!irst_n) begin
            state_q <= IDLE;
            win_q   <= 1'b0;
            cx_q    <= '0;
            cy_q    <= '0;
            sof_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            sof_q   <= sof_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign owin_valid  = win_q;
    assign ocx         = cx_q;
    assign ocy         = cy_q;
    assign osof        = sof_q;
    assign oframe_done = done_q;
    assign obusy       = busy;
    assign oerr        = err_q;

endmodule

// File: tb/tb_window_scan_ctrl.sv
// Self-checking bench for window_scan_ctrl on an 8x6 image.
// Randomized pixel gaps checked against a raster-order window list model.
module tb_window_scan_ctrl;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int CW = 4;
    localparam int RW = 3;
    localparam int NPIX = W * H;
    localparam int NWIN = (W - 2) * (H - 2);

    logic iclk = 1'b0;
    logic irst_n;
    logic istart;
    logic ivalid;
    logic oshift_en;
    logic owin_valid;
    logic [CW-1:0] ocx;
    logic [RW-1:0] ocy;
    logic osof;
    logic oframe_done;
    logic obusy;
    logic oerr;

    int checks = 0;
    int errors = 0;

    window_scan_ctrl #(
        .IMG_W (W),
        .IMG_H (H),
        .COL_W (CW),
        .ROW_W (RW)
    ) dut (
        .iclk        (iclk),
        .irst_n      (irst_n),
        .istart      (istart),
        .ivalid      (ivalid),
        .oshift_en   (oshift_en),
        .owin_valid  (owin_valid),
        .ocx         (ocx),
        .ocy         (ocy),
        .osof        (osof),
        .oframe_done (oframe_done),
        .obusy       (obusy),
        .oerr        (oerr)
    );

    always #5 iclk = ~iclk;

    int cyc = 0;
    logic last_iv = 1'b0;
    int wx_q[$];
    int wy_q[$];
    int ws_q[$];
    int fd_n = 0;
    int fd_cyc = -1;
    int bad_win = 0;
    int ex_x[$];
    int ex_y[$];
    int last_px = 0;

    always @(posedge iclk) begin
        cyc <= cyc + 1;
        last_iv <= ivalid;
    end

    always @(negedge iclk) begin
        if (irst_n) begin
            if (owin_valid) begin
                wx_q.push_back(int'(ocx));
                wy_q.push_back(int'(ocy));
                ws_q.push_back(int'(osof));
                if (!last_iv) bad_win++;
            end
            if (oframe_done) begin
                fd_n++;
                fd_cyc = cyc;
            end
        end
    end

    task automatic clear_mon();
        wx_q.delete();
        wy_q.delete();
        ws_q.delete();
        fd_n = 0;
        fd_cyc = -1;
        bad_win = 0;
    endtask

    task automatic build_model();
        ex_x.delete();
        ex_y.delete();
        for (int r = 1; r <= H - 2; r++)
            for (int c = 1; c <= W - 2; c++) begin
                ex_x.push_back(c);
                ex_y.push_back(r);
            end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(posedge iclk);
            #1;
        end
    endtask

    task automatic pulse_start();
        istart = 1'b1;
        @(posedge iclk);
        #1;
        istart = 1'b0;
    endtask

    task automatic push_pixels(int n, bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                for (int g = 0; g < 4; g++) begin
                    if ($urandom_range(1, 0) == 0) break;
                    @(posedge iclk);
                    #1;
                end
            end
            ivalid = 1'b1;
            @(posedge iclk);
            #1;
            last_px = cyc;
            ivalid = 1'b0;
        end
    endtask

    task automatic check_frame(string nm);
        int mism;
        int sofs;
        mism = 0;
        sofs = 0;
        checks++;
        if (wx_q.size() !== NWIN) begin
            errors++;
            $display("FAIL %s count: got %0d want %0d", nm, wx_q.size(), NWIN);
        end
        checks++;
        for (int i = 0; i < wx_q.size() && i < NWIN; i++) begin
            if (wx_q[i] != ex_x[i] || wy_q[i] != ex_y[i]) begin
                if (mism == 0)
                    $display("FAIL %s order[%0d]: got (%0d,%0d) want (%0d,%0d)",
                             nm, i, wx_q[i], wy_q[i], ex_x[i], ex_y[i]);
                mism++;
            end
        end
        if (mism != 0) errors++;
        foreach (ws_q[i]) sofs += ws_q[i];
        checks++;
        if (sofs != 1 || ws_q.size() == 0 || ws_q[0] != 1) begin
            errors++;
            $display("FAIL %s sof: got %0d pulses want 1 on first", nm, sofs);
        end
        checks++;
        if (fd_n != 1 || fd_cyc != last_px) begin
            errors++;
            $display("FAIL %s done: got %0d at %0d want 1 at %0d",
                     nm, fd_n, fd_cyc, last_px);
        end
        checks++;
        if (bad_win != 0) begin
            errors++;
            $display("FAIL %s win_no_accept: got %0d want 0", nm, bad_win);
        end
    endtask

    task automatic run_frame(string nm, bit gaps);
        clear_mon();
        pulse_start();
        push_pixels(NPIX, gaps);
        checks++;
        if (oframe_done !== 1'b1 || obusy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle: got done=%b busy=%b want 1 0",
                     nm, oframe_done, obusy);
        end
        idle(3);
        check_frame(nm);
    endtask

    task automatic test_reset();
        irst_n = 1'b0;
        #1;
        checks++;
        if ({owin_valid, ocx, ocy, osof, oframe_done, obusy, oerr, oshift_en} !== '0) begin
            errors++;
            $display("FAIL reset: got %b want 0",
                     {owin_valid, ocx, ocy, osof, oframe_done, obusy, oerr, oshift_en});
        end
        idle(2);
        irst_n = 1'b1;
        idle(1);
    endtask

    task automatic test_early_valid();
        ivalid = 1'b1;
        #1;
        checks++;
        if (oshift_en !== 1'b0) begin
            errors++;
            $display("FAIL early_shift: got %b want 0", oshift_en);
        end
        @(posedge iclk);
        #1;
        ivalid = 1'b0;
        checks++;
        if (oerr !== 1'b1 || owin_valid !== 1'b0 || obusy !== 1'b0) begin
            errors++;
            $display("FAIL early_err: got err=%b win=%b busy=%b want 1 0 0",
                     oerr, owin_valid, obusy);
        end
        idle(1);
        checks++;
        if (oerr !== 1'b0) begin
            errors++;
            $display("FAIL early_pulse: got %b want 0", oerr);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        push_pixels(20, 1'b0);
        irst_n = 1'b0;
        #1;
        checks++;
        if ({owin_valid, ocx, ocy, osof, oframe_done, obusy, oerr} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got %b want 0",
                     {owin_valid, ocx, ocy, osof, oframe_done, obusy, oerr});
        end
        #2;
        irst_n = 1'b1;
        idle(2);
        run_frame("after_reset", 1'b0);
    endtask

    task automatic test_restart();
        clear_mon();
        pulse_start();
        push_pixels(30, 1'b1);
        pulse_start();
        checks++;
        if (oerr !== 1'b1 || obusy !== 1'b1) begin
            errors++;
            $display("FAIL restart_err: got err=%b busy=%b want 1 1", oerr, obusy);
        end
        clear_mon();
        push_pixels(18, 1'b1);
        idle(2);
        checks++;
        if (wx_q.size() != 0) begin
            errors++;
            $display("FAIL restart_early_win: got %0d want 0", wx_q.size());
        end
        push_pixels(1, 1'b0);
        checks++;
        if (owin_valid !== 1'b1 || ocx !== 4'd1 || ocy !== 3'd1 || osof !== 1'b1) begin
            errors++;
            $display("FAIL restart_first: got v=%b (%0d,%0d) sof=%b want 1 (1,1) 1",
                     owin_valid, ocx, ocy, osof);
        end
        push_pixels(NPIX - 19, 1'b1);
        idle(3);
        check_frame("restart");
    endtask

    task automatic test_back_to_back();
        clear_mon();
        pulse_start();
        push_pixels(NPIX, 1'b0);
        istart = 1'b1;
        @(posedge iclk);
        #1;
        istart = 1'b0;
        checks++;
        if (oerr !== 1'b0 || obusy !== 1'b1) begin
            errors++;
            $display("FAIL done_start: got err=%b busy=%b want 0 1", oerr, obusy);
        end
        clear_mon();
        push_pixels(NPIX, 1'b1);
        idle(3);
        check_frame("second_frame");
    endtask

    initial begin
        istart = 1'b0;
        ivalid = 1'b0;
        build_model();
        test_reset();
        test_early_valid();
        run_frame("b2b_frame", 1'b0);
        run_frame("gap_frame", 1'b1);
        test_reset_mid();
        test_restart();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1);
    end

endmodule
